counter_sweep_ctrl: RTL and testbench



---
 rtl/counter_sweep_pkg.sv | 15 +
 rtl/sweep_counter.sv | 39 +++
 rtl/counter_sweep_ctrl.sv | 153 +++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_sweep_pkg.sv
// Shared types and defaults for the counter sweep controller and its datapath.
package counter_sweep_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_REPW  = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        UP   = 3'd2,
        DOWN = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/sweep_counter.sv
// Loadable up/down counter datapath; load takes priority over enable.
module sweep_counter
    import counter_sweep_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (en) begin
            count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    // NOTE: state flops use <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Triangular sweep controller (lo -> hi -> lo, reps+1 passes) around sweep_counter.
// Optional freeze input enabled by defining COUNTER_SWEEP_HOLD_EN.
module counter_sweep_ctrl
    import counter_sweep_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int REPW  = DEFAULT_REPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [REPW-1:0]  reps,
`ifdef COUNTER_SWEEP_HOLD_EN
    input  logic             hold,
`endif
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             dir_up
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [REPW-1:0]  pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             dir_up_q, dir_up_d;

    logic             hold_w;
    logic             cnt_load, cnt_en, cnt_up;
    logic [WIDTH-1:0] count;

`ifdef COUNTER_SWEEP_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        pass_d   = pass_q;
        err_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_up   = 1'b0;

        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        if (lo < hi) begin
                            lo_d    = lo;
                            hi_d    = hi;
                            pass_d  = reps;
                            state_d = LOAD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (!hold_w) begin
                        cnt_load = 1'b1;
                        state_d  = UP;
                    end
                end
                UP: begin
                    if (!hold_w) begin
                        cnt_en = 1'b1;
                        if (count != hi_q) begin
                            cnt_up = 1'b1;
                        end else begin
                            state_d = DOWN;
                        end
                    end
                end
                DOWN: begin
                    if (!hold_w) begin
                        if (count != lo_q) begin
                            cnt_en = 1'b1;
                        end else if (pass_q != '0) begin
                            pass_d  = pass_q - REPW'(1);
                            cnt_en  = 1'b1;
                            cnt_up  = 1'b1;
                            state_d = UP;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they line up with the registered state.
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        dir_up_d = (state_d == UP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            pass_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            dir_up_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            dir_up_q <= dir_up_d;
        end
    end

    sweep_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (cnt_en),
        .up        (cnt_up),
        .load      (cnt_load),
        .load_value(lo_q),
        .count     (count)
    );

    assign count_out = count;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dir_up    = dir_up_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Self-checking bench for counter_sweep_ctrl: a per-edge expected trace is queued and popped against the DUT.
module tb_counter_sweep_ctrl;

    typedef struct {
        logic [3:0] count;
        logic       busy;
        logic       done;
        logic       dir_up;
        logic       hold_drv;
        logic       abort_drv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] lo = '0;
    logic [3:0] hi = '0;
    logic [2:0] reps = '0;
    logic [3:0] count_out;
    logic       busy, done, err, dir_up;

    exp_t sb_q[$];
    int   checks_total = 0;
    int   checks_passed = 0;
    int   model_count = 0;

    always #5 clk = ~clk;

    counter_sweep_ctrl #(.WIDTH(4), .REPW(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .lo       (lo),
        .hi       (hi),
        .reps     (reps),
`ifdef COUNTER_SWEEP_HOLD_EN
        .hold     (hold),
`endif
        .count_out(count_out),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .dir_up   (dir_up)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks_total++;
        if (obs == exp) checks_passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic exp_t mk(input int v, input logic b, input logic d, input logic u,
                                input logic h, input logic a);
        exp_t e;
        e.count = 4'(v); e.busy = b; e.done = d; e.dir_up = u;
        e.hold_drv = h; e.abort_drv = a;
        return e;
    endfunction

    // Expected trace: entry k is the DUT state after edge Ek, plus what to drive before Ek.
    task automatic build(input int l, input int h, input int r, input int hold_val,
                         input int hold_n, input int abort_idx);
        bit held = 0;
        int c;
        sb_q.delete();
        sb_q.push_back(mk(model_count, 1, 0, 0, 0, 0));
        for (int p = 0; p <= r; p++) begin
            for (int v = (p == 0) ? l : l + 1; v <= h; v++) begin
                sb_q.push_back(mk(v, 1, 0, 1, 0, 0));
                if (hold_n > 0 && !held && v == hold_val) begin
                    for (int i = 0; i < hold_n; i++) sb_q.push_back(mk(v, 1, 0, 1, 1, 0));
                    held = 1;
                end
            end
            for (int v = h - 1; v >= l; v--) sb_q.push_back(mk(v, 1, 0, 0, 0, 0));
        end
        sb_q.push_back(mk(l, 1, 1, 0, 0, 0));
        sb_q.push_back(mk(l, 0, 0, 0, 0, 0));
        if (abort_idx > 0) begin
            c = int'(sb_q[abort_idx-1].count);
            while (sb_q.size() > abort_idx) void'(sb_q.pop_back());
            sb_q.push_back(mk(c, 0, 0, 0, 0, 1));
            sb_q.push_back(mk(c, 0, 0, 0, 0, 0));
            sb_q.push_back(mk(c, 0, 0, 0, 0, 0));
        end
        model_count = int'(sb_q[sb_q.size()-1].count);
    endtask

    // Drives one sweep from the queued trace; exp_done_k < 0 means no done pulse is expected.
    task automatic run(input string tag, input int l, input int h, input int r,
                       input bit noise, input int exp_done_k);
        exp_t e;
        int n = sb_q.size();
        int done_cnt = 0;
        int done_k = -1;
        for (int k = 0; k < n; k++) begin
            e = sb_q.pop_front();
            if (k == 0) begin
                start = 1'b1; lo = 4'(l); hi = 4'(h); reps = 3'(r);
            end else if (noise && k >= 2 && k <= n - 3) begin
                start = 1'b1;
                lo = 4'($urandom_range(0, 15)); hi = 4'($urandom_range(0, 15));
                reps = 3'($urandom_range(0, 7));
            end else begin
                start = 1'b0;
            end
            abort = e.abort_drv;
            hold  = e.hold_drv;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s count k=%0d", tag, k), int'(count_out), int'(e.count));
            check($sformatf("%s busy k=%0d", tag, k), int'(busy), int'(e.busy));
            check($sformatf("%s done k=%0d", tag, k), int'(done), int'(e.done));
            check($sformatf("%s dir_up k=%0d", tag, k), int'(dir_up), int'(e.dir_up));
            check($sformatf("%s err k=%0d", tag, k), int'(err), 0);
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
        end
        start = 1'b0; abort = 1'b0; hold = 1'b0;
        check({tag, " done_cnt"}, done_cnt, (exp_done_k < 0) ? 0 : 1);
        if (exp_done_k >= 0) check({tag, " done_edge"}, done_k, exp_done_k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check("rst count", int'(count_out), 0);
        check("rst flags", int'({busy, done, err, dir_up}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Rejected starts: lo == hi and lo > hi
        start = 1'b1; lo = 4'd7; hi = 4'd7;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        check("rej_eq err", int'(err), 1);
        check("rej_eq busy", int'(busy), 0);
        @(posedge clk); @(negedge clk);
        check("rej_eq err pulse", int'(err), 0);
        start = 1'b1; lo = 4'd9; hi = 4'd3;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        check("rej_gt err", int'(err), 1);
        check("rej_gt busy", int'(busy), 0);

        // Basic sweep, repeat sweep, full range
        build(2, 5, 0, 0, 0, 0);  run("basic", 2, 5, 0, 0, 8);
        build(2, 5, 1, 0, 0, 0);  run("repeat", 2, 5, 1, 0, 14);
        build(0, 15, 0, 0, 0, 0); run("full", 0, 15, 0, 0, 32);

        // Abort during DOWN at count 4 (after E5)
        build(2, 5, 0, 0, 0, 6);  run("abort", 2, 5, 0, 0, -1);

        // start and abort together in IDLE: both discarded, even for bad bounds
        start = 1'b1; abort = 1'b1; lo = 4'd1; hi = 4'd3;
        @(posedge clk); @(negedge clk);
        check("sa_idle busy", int'(busy), 0);
        check("sa_idle count", int'(count_out), model_count);
        lo = 4'd8; hi = 4'd2;
        @(posedge clk); @(negedge clk);
        check("sa_idle err", int'(err), 0);
        check("sa_idle busy2", int'(busy), 0);
        start = 1'b0; abort = 1'b0;
        @(posedge clk); @(negedge clk);
        check("sa_idle stays", int'(busy), 0);

        // Start while busy plus input churn during the sweep
        build(3, 6, 1, 0, 0, 0);  run("noisy", 3, 6, 1, 1, 14);

`ifdef COUNTER_SWEEP_HOLD_EN
        build(2, 5, 0, 3, 3, 0);  run("hold", 2, 5, 0, 0, 11);
`endif

        // Asynchronous reset during UP at count 4
        start = 1'b1; lo = 4'd2; hi = 4'd5; reps = 3'd0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst count", int'(count_out), 4);
        check("pre_rst dir_up", int'(dir_up), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst count", int'(count_out), 0);
        check("mid_rst flags", int'({busy, done, err, dir_up}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
        end
        check("post_rst busy", int'(busy), 0);
        check("post_rst count", int'(count_out), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
